// File: rtl/booth_multiplier_top.sv
// booth_multiplier_top: 8x8 signed radix-2 Booth multiplier with LED and 8-digit 7-segment output.
// Define BOOTH_DEBOUNCE_EN to insert a pushbutton debouncer after the synchronizer.
module booth_multiplier_top #(
    parameter int REFRESH_BITS = 17,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        pb_entrada,
    output logic [15:0] LED,
    output logic        LED_reset,
    output logic        LED_pb,
    output logic [7:0]  anodo,
    output logic [6:0]  catodo
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  pb_sync;
    logic        pb_level, pb_prev, start;
    logic [7:0]  a_reg, q;
    logic [8:0]  p, a_ext, p_sum;
    logic        q_1;
    logic [2:0]  count;
    logic [REFRESH_BITS+2:0] refresh;
    logic [2:0]  digit;
    logic [3:0]  nibble;

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) pb_sync <= '0;
        else        pb_sync <= {pb_sync[0], pb_entrada};

`ifdef BOOTH_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    logic [DW-1:0] db_cnt;
    logic          db_level;

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (pb_sync[1] == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_level <= pb_sync[1];
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end

    assign pb_level = db_level;
`else
    assign pb_level = pb_sync[1];
`endif

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) pb_prev <= 1'b0;
        else        pb_prev <= pb_level;

    assign start     = pb_level & ~pb_prev;
    assign LED_pb    = pb_level;
    assign LED_reset = ~reset;

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = CALC;
            CALC:    state_next = (count == 3'd7) ? DONE : CALC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // P carries a guard bit so that subtracting A=-128 cannot overflow (-128*-128 stays exact).
    assign a_ext = {a_reg[7], a_reg};
    assign p_sum = ({q[0], q_1} == 2'b10) ? p - a_ext :
                   ({q[0], q_1} == 2'b01) ? p + a_ext : p;

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) begin
            a_reg <= '0;
            p     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            LED   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    a_reg <= A;
                    p     <= '0;
                    q     <= B;
                    q_1   <= 1'b0;
                    count <= '0;
                end
                CALC: begin
                    p     <= {p_sum[8], p_sum[8:1]};
                    q     <= {p_sum[0], q[7:1]};
                    q_1   <= q[0];
                    count <= count + 1'b1;
                end
                DONE:    LED <= {p[7:0], q};
                default: ;
            endcase
        end

    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) refresh <= '0;
        else        refresh <= refresh + 1'b1;

    assign digit = refresh[REFRESH_BITS+2:REFRESH_BITS];
    assign anodo = ~(8'd1 << digit);

    always_comb begin
        case (digit)
            3'd7:    nibble = A[7:4];
            3'd6:    nibble = A[3:0];
            3'd5:    nibble = B[7:4];
            3'd4:    nibble = B[3:0];
            3'd3:    nibble = LED[15:12];
            3'd2:    nibble = LED[11:8];
            3'd1:    nibble = LED[7:4];
            default: nibble = LED[3:0];
        endcase
    end

    // Glyphs listed as {g,f,e,d,c,b,a}, active-low.
    always_comb begin
        case (nibble)
            4'h0:    catodo = 7'b1000000;
            4'h1:    catodo = 7'b1111001;
            4'h2:    catodo = 7'b0100100;
            4'h3:    catodo = 7'b0110000;
            4'h4:    catodo = 7'b0011001;
            4'h5:    catodo = 7'b0010010;
            4'h6:    catodo = 7'b0000010;
            4'h7:    catodo = 7'b1111000;
            4'h8:    catodo = 7'b0000000;
            4'h9:    catodo = 7'b0010000;
            4'hA:    catodo = 7'b0001000;
            4'hB:    catodo = 7'b0000011;
            4'hC:    catodo = 7'b1000110;
            4'hD:    catodo = 7'b0100001;
            4'hE:    catodo = 7'b0000110;
            default: catodo = 7'b0001110;
        endcase
    end
endmodule

// File: tb/tb_booth_multiplier_top.sv
// tb_booth_multiplier_top: directed vectors for booth_multiplier_top with a fast display refresh.
module tb_booth_multiplier_top;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a, b;
    logic        pb;
    logic [15:0] led;
    logic        led_reset, led_pb;
    logic [7:0]  anodo;
    logic [6:0]  catodo;
    int          n_cmp = 0;
    int          n_err = 0;

    booth_multiplier_top #(.REFRESH_BITS(2)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .A         (a),
        .B         (b),
        .pb_entrada(pb),
        .LED       (led),
        .LED_reset (led_reset),
        .LED_pb    (led_pb),
        .anodo     (anodo),
        .catodo    (catodo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
        @(negedge clk);
        a  = x;
        b  = y;
        pb = 1'b1;
        repeat (3) @(negedge clk);
        pb = 1'b0;
        repeat (16) @(negedge clk);
        check(tag, {16'h0, led}, {16'h0, exp});
    endtask

    task automatic scan(input int i, input logic [6:0] exp, input string tag);
        logic [7:0] want;
        int         n;
        want = ~(8'd1 << i);
        n = 0;
        @(negedge clk);
        while (anodo !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_anodo"}, {24'h0, anodo}, {24'h0, want});
        check({tag, "_catodo"}, {25'h0, catodo}, {25'h0, exp});
    endtask

    initial begin
        int n;
        reset = 1'b0;
        pb    = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #15;
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_led_reset", {31'h0, led_reset}, 32'h1);
        check("rst_anodo", {24'h0, anodo}, 32'hFE);
        check("rst_led_pb", {31'h0, led_pb}, 32'h0);
        #5 reset = 1'b1;
        @(negedge clk);
        check("led_reset_off", {31'h0, led_reset}, 32'h0);

        @(negedge clk);
        a  = 8'd8;
        b  = 8'd7;
        pb = 1'b1;
        @(posedge clk) #1;
        check("led_pb_1clk", {31'h0, led_pb}, 32'h0);
        @(posedge clk) #1;
        check("led_pb_2clk", {31'h0, led_pb}, 32'h1);
        n = 0;
        while (led !== 16'h0038 && n < 12) begin
            @(posedge clk) #1;
            n++;
        end
        check("mul_8x7", {16'h0, led}, 32'h0038);
        check("latency", n, 11);
        pb = 1'b0;

        @(negedge clk);
        a = 8'hA7;
        scan(0, 7'b0000000, "dig0");
        scan(1, 7'b0110000, "dig1");
        scan(2, 7'b1000000, "dig2");
        scan(4, 7'b1111000, "dig4");
        scan(5, 7'b1000000, "dig5");
        scan(6, 7'b1111000, "dig6");
        scan(7, 7'b0001000, "dig7");
        check("led_unchanged_by_a", {16'h0, led}, 32'h0038);

        mul(8'h80, 8'h80, 16'h4000, "mul_m128xm128");
        mul(8'h7F, 8'h80, 16'hC080, "mul_127xm128");
        mul(8'h7F, 8'h7F, 16'h3F01, "mul_127x127");
        mul(8'h80, 8'h01, 16'hFF80, "mul_m128x1");
        mul(8'h00, 8'h55, 16'h0000, "mul_0x85");

        @(negedge clk);
        a  = 8'hFF;
        b  = 8'h01;
        pb = 1'b1;
        repeat (16) @(negedge clk);
        check("mul_m1x1", {16'h0, led}, 32'hFFFF);
        a = 8'h03;
        repeat (20) @(negedge clk);
        check("hold_no_restart", {16'h0, led}, 32'hFFFF);
        pb = 1'b0;
        repeat (4) @(negedge clk);

        a  = 8'd5;
        b  = 8'd9;
        pb = 1'b1;
        repeat (2) @(negedge clk);
        pb = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_led", {16'h0, led}, 32'h0);
        check("abort_led_reset", {31'h0, led_reset}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_stays_idle", {16'h0, led}, 32'h0);
        mul(8'hFD, 8'h07, 16'hFFEB, "restart_m3x7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
